prg_load_ctrl: RTL and testbench
================================

# prg_load_ctrl

Sequencer that moves a downloaded PRG byte stream into C16 main RAM through a shared single write port. It strips the 2-byte little-endian load-address header and writes each payload byte with a req/ack handshake. On session end it patches the BASIC end-of-program pointers ($2D–$32, $AE/$AF). It sits in the `clk_sys` domain between the HPS download interface and the main-RAM write-port arbiter.

## Interface
- `ACK_TO`, default 255: max cycles `ram_req` may wait for `ram_ack` before abort; 1..255.
- `clk_sys`  in  1  system clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `dl_active`  in  1  download session active (level).
- `dl_valid`  in  1  byte strobe; qualifies `dl_data`.
- `dl_data`  in  8  stream byte.
- `dl_ready`  out  1  controller can accept a byte this cycle.
- `ram_req`  out  1  write request; held with stable `ram_addr`/`ram_data` until ack.
- `ram_addr`  out  16  write address.
- `ram_data`  out  8  write data.
- `ram_ack`  in  1  arbiter accepted the write (one-cycle pulse).
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  one-cycle pulse: load complete.
- `error`  out  1  one-cycle pulse: short header or ack timeout.
- `overflow`  out  1  sticky: payload ran past $FFFF; cleared at next session start.
- `end_addr`  out  16  address after the last written payload byte; valid from `done`.

## Operation
- States: IDLE, HDR_LO, HDR_HI, DATA, WRITE, PATCH, FIN.
- IDLE → HDR_LO on `dl_active` high. Clear `overflow`.
- A byte transfers when `dl_valid & dl_ready`. `dl_ready` = 1 only in HDR_LO, HDR_HI and DATA, with no request outstanding.
- HDR_LO: byte → `addr[7:0]`, go to HDR_HI.
- HDR_HI: byte → `addr[15:8]`, go to DATA.
- DATA: on transfer, latch `ram_addr=addr`, `ram_data=byte`, go to WRITE.
- WRITE: hold `ram_req` until `ram_ack`.
  - On ack: `addr` increments (16-bit wrap).
  - Return to DATA.
- Wrap rule: a write at $FFFF sets `overflow`. Later bytes are accepted (`dl_ready` stays 1) but discarded, with no `ram_req`. `end_addr` freezes at $0000.
- `dl_active` falls:
  - In HDR_LO/HDR_HI: pulse `error`, go to IDLE, no writes.
  - In DATA: `end_addr<=addr`, go to PATCH.
  - In WRITE: complete the pending write first, then go to PATCH.
- PATCH: 8 sequential writes, each with the same handshake: $2D/$2E, $2F/$30, $31/$32, $AE/$AF. Each pair gets `end_addr` lo then hi.
- FIN: pulse `done` for one cycle, then IDLE.
- Timeout: 8-bit counter runs while `ram_req`=1. At `ACK_TO` cycles without ack: drop `ram_req`, pulse `error`, go to IDLE (no patch).
- `dl_active` rising during PATCH/FIN: ignored. A new session starts only from IDLE with `dl_active` high.
- Reset (any state, including mid-handshake): all outputs 0, state IDLE, `addr`=0, `end_addr`=0. No request survives.

## Timing
- Byte accepted at edge N → `ram_req`=1 from N+1.
- `ram_ack` sampled at edge M → `ram_req`=0 from M+1. Next byte is accepted no earlier than M+1.
- Minimum 2 cycles per payload byte with same-cycle ack.
- Patch write k+1 issues the cycle after ack k.
- `done` is high the cycle after the 8th patch ack.
- `error` is high the cycle after the detecting edge.
- `ram_addr`/`ram_data` are stable throughout every request.

## Configuration
- `PRG_PTR_PATCH_EN` defined: PATCH state built; the 8 pointer writes occur as above.
- Not defined: PATCH omitted; session end goes DATA/WRITE → FIN directly. `end_addr` is still reported, and no RAM write occurs outside the payload range.

## Test plan
- Stream $01,$10,$AA,$BB,$CC, ack same cycle → writes $1001=$AA, $1002=$BB, $1003=$CC; patches $2D=$04, $2E=$10 … $AE=$04, $AF=$10; `end_addr`=$1004; one `done` pulse.
- Ack delayed 5 cycles per write → `ram_req` held 6 cycles with stable addr/data; `dl_ready`=0 throughout; final memory image identical to the previous case.
- Header $FE,$FF, then 4 bytes → writes at $FFFE and $FFFF only; `overflow`=1; 2 bytes discarded; `end_addr`=$0000.
- `dl_active` drops after 1 byte → `error` pulse, zero `ram_req`, state IDLE.
- `ram_ack` never asserted, `ACK_TO`=8 → `ram_req` drops after 8 cycles, `error` pulse, no `done`.
- `reset_n` low during the 3rd patch write → all outputs 0 immediately. After release, a new session loads correctly. Repeat with `PRG_PTR_PATCH_EN` undefined: no writes below payload address.

Source files
------------

// File: rtl/prg_load_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : prg_load_ctrl
//  Purpose  : Streams a PRG download into main RAM: strips the load-address
//             header, writes the payload through a req/ack write port and
//             patches the BASIC end-of-program pointers when the session ends.
//             The pointer patch is built only with PRG_PTR_PATCH_EN defined.
//  Revision : 1.0  initial release
// ============================================================================
module prg_load_ctrl #(
   parameter int unsigned ACK_TO = 255
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        dl_active,
   input  logic        dl_valid,
   input  logic [7:0]  dl_data,
   output logic        dl_ready,
   output logic        ram_req,
   output logic [15:0] ram_addr,
   output logic [7:0]  ram_data,
   input  logic        ram_ack,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic        overflow,
   output logic [15:0] end_addr
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_HDR_LO = 3'd1,
      S_HDR_HI = 3'd2,
      S_DATA   = 3'd3,
      S_WRITE  = 3'd4,
      S_PATCH  = 3'd5,
      S_FIN    = 3'd6
   } state_t;

   localparam logic [7:0] c_to_last = 8'(ACK_TO - 1);

   state_t      r_state;
   logic [15:0] r_addr;
   logic [15:0] r_end_addr;
   logic [15:0] r_ram_addr;
   logic [7:0]  r_ram_data;
   logic [7:0]  r_to_cnt;
   logic        r_ram_req;
   logic        r_done;
   logic        r_error;
   logic        r_overflow;

   logic        w_xfer;
   logic        w_timeout;
   logic [15:0] w_addr_inc;

`ifdef PRG_PTR_PATCH_EN
   logic [2:0]  r_patch_idx;

   // Pointer pairs $2D/$2E, $2F/$30, $31/$32, $AE/$AF; even index = low byte.
   function automatic logic [15:0] f_patch_addr(input logic [2:0] idx);
      logic [15:0] v;
      v = 16'h0000;
      case (idx)
         3'd0: v = 16'h002D;
         3'd1: v = 16'h002E;
         3'd2: v = 16'h002F;
         3'd3: v = 16'h0030;
         3'd4: v = 16'h0031;
         3'd5: v = 16'h0032;
         3'd6: v = 16'h00AE;
         default: v = 16'h00AF;
      endcase
      return v;
   endfunction
`endif

   // Ready drops with dl_active so a byte is never taken in the ending cycle.
   assign dl_ready = dl_active && !r_ram_req &&
                     ((r_state == S_HDR_LO) || (r_state == S_HDR_HI) || (r_state == S_DATA));
   assign w_xfer     = dl_valid && dl_ready;
   assign w_timeout  = r_ram_req && !ram_ack && (r_to_cnt == c_to_last);
   assign w_addr_inc = r_addr + 16'd1;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= S_IDLE;
         r_addr     <= 16'h0000;
         r_end_addr <= 16'h0000;
         r_ram_addr <= 16'h0000;
         r_ram_data <= 8'h00;
         r_to_cnt   <= 8'h00;
         r_ram_req  <= 1'b0;
         r_done     <= 1'b0;
         r_error    <= 1'b0;
         r_overflow <= 1'b0;
`ifdef PRG_PTR_PATCH_EN
         r_patch_idx <= 3'd0;
`endif
      end else begin
         r_done  <= 1'b0;
         r_error <= 1'b0;

         if (r_ram_req && !ram_ack)
            r_to_cnt <= r_to_cnt + 8'd1;
         else
            r_to_cnt <= 8'h00;

         if (w_timeout) begin
            r_ram_req <= 1'b0;
            r_error   <= 1'b1;
            r_state   <= S_IDLE;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (dl_active) begin
                     r_overflow <= 1'b0;
                     r_state    <= S_HDR_LO;
                  end
               end
               S_HDR_LO: begin
                  if (!dl_active) begin
                     r_error <= 1'b1;
                     r_state <= S_IDLE;
                  end else if (w_xfer) begin
                     r_addr[7:0] <= dl_data;
                     r_state     <= S_HDR_HI;
                  end
               end
               S_HDR_HI: begin
                  if (!dl_active) begin
                     r_error <= 1'b1;
                     r_state <= S_IDLE;
                  end else if (w_xfer) begin
                     r_addr[15:8] <= dl_data;
                     r_state      <= S_DATA;
                  end
               end
               S_DATA: begin
                  if (!dl_active) begin
                     r_end_addr <= r_addr;
`ifdef PRG_PTR_PATCH_EN
                     r_patch_idx <= 3'd0;
                     r_state     <= S_PATCH;
`else
                     r_done  <= 1'b1;
                     r_state <= S_FIN;
`endif
                  end else if (w_xfer && !r_overflow) begin
                     // After a wrap past $FFFF bytes are accepted but dropped.
                     r_ram_addr <= r_addr;
                     r_ram_data <= dl_data;
                     r_ram_req  <= 1'b1;
                     r_state    <= S_WRITE;
                  end
               end
               S_WRITE: begin
                  if (ram_ack) begin
                     r_ram_req <= 1'b0;
                     r_addr    <= w_addr_inc;
                     if (r_addr == 16'hFFFF)
                        r_overflow <= 1'b1;
                     if (!dl_active) begin
                        r_end_addr <= w_addr_inc;
`ifdef PRG_PTR_PATCH_EN
                        r_patch_idx <= 3'd0;
                        r_state     <= S_PATCH;
`else
                        r_done  <= 1'b1;
                        r_state <= S_FIN;
`endif
                     end else begin
                        r_state <= S_DATA;
                     end
                  end
               end
`ifdef PRG_PTR_PATCH_EN
               S_PATCH: begin
                  if (!r_ram_req) begin
                     r_ram_req  <= 1'b1;
                     r_ram_addr <= f_patch_addr(r_patch_idx);
                     r_ram_data <= r_patch_idx[0] ? r_end_addr[15:8] : r_end_addr[7:0];
                  end else if (ram_ack) begin
                     r_ram_req <= 1'b0;
                     if (r_patch_idx == 3'd7) begin
                        r_done  <= 1'b1;
                        r_state <= S_FIN;
                     end else begin
                        r_patch_idx <= r_patch_idx + 3'd1;
                     end
                  end
               end
`endif
               S_FIN: begin
                  r_state <= S_IDLE;
               end
               default: begin
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign ram_req  = r_ram_req;
   assign ram_addr = r_ram_addr;
   assign ram_data = r_ram_data;
   assign busy     = (r_state != S_IDLE);
   assign done     = r_done;
   assign error    = r_error;
   assign overflow = r_overflow;
   assign end_addr = r_end_addr;

endmodule
`default_nettype wire

// File: tb/tb_prg_load_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prg_load_ctrl
//  Purpose  : Scoreboard bench for prg_load_ctrl; expected RAM writes come from
//             a session-level model and are popped by the RAM-port responder.
//  Revision : 1.0  initial release
// ============================================================================
module tb_prg_load_ctrl;

   typedef logic [7:0] byte_q_t [$];
   typedef struct packed {
      logic [15:0] a;
      logic [7:0]  d;
   } wr_t;

   logic        clk_sys = 1'b0;
   logic        rst_main_n = 1'b0;
   logic        rst_inj_n = 1'b1;
   logic        reset_n;
   logic        dl_active = 1'b0;
   logic        dl_valid = 1'b0;
   logic [7:0]  dl_data = 8'h00;
   logic        dl_ready;
   logic        ram_req;
   logic [15:0] ram_addr;
   logic [7:0]  ram_data;
   logic        ram_ack = 1'b0;
   logic        busy;
   logic        done;
   logic        error;
   logic        overflow;
   logic [15:0] end_addr;

   assign reset_n = rst_main_n & rst_inj_n;

   prg_load_ctrl #(.ACK_TO(8)) u_dut (
      .clk_sys   (clk_sys),
      .reset_n   (reset_n),
      .dl_active (dl_active),
      .dl_valid  (dl_valid),
      .dl_data   (dl_data),
      .dl_ready  (dl_ready),
      .ram_req   (ram_req),
      .ram_addr  (ram_addr),
      .ram_data  (ram_data),
      .ram_ack   (ram_ack),
      .busy      (busy),
      .done      (done),
      .error     (error),
      .overflow  (overflow),
      .end_addr  (end_addr)
   );

   always #5 clk_sys = ~clk_sys;

   int  n_cmp = 0;
   int  n_bad = 0;
   wr_t exp_q [$];

   int  ack_delay = 0;
   bit  ack_en = 1'b1;
   int  ack_cnt = 0;
   int  req_cycles = 0;
   int  done_cnt = 0;
   int  err_cnt = 0;
   int  inject_at = -1;
   int  inject_cnt = 0;
   int  inj_seen = 0;
   int  ack_base = 0;

`ifdef PRG_PTR_PATCH_EN
   localparam logic [63:0] c_ptrs = 64'h2D2E2F303132AEAF;
`endif

   function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
      end
   endfunction

   // RAM-port responder and scoreboard monitor.
   logic        in_req = 1'b0;
   logic [15:0] hold_a = 16'h0;
   logic [7:0]  hold_d = 8'h0;
   int          wcnt = 0;
   always @(negedge clk_sys) begin
      wr_t e;
      ram_ack = 1'b0;
      if (!reset_n) begin
         in_req = 1'b0;
         wcnt   = 0;
      end else if (ram_req) begin
         req_cycles++;
         if (!in_req) begin
            in_req = 1'b1;
            hold_a = ram_addr;
            hold_d = ram_data;
            wcnt   = 0;
         end else begin
            check("req_stable", {40'h0, ram_addr, ram_data}, {40'h0, hold_a, hold_d});
         end
         check("ready_low_in_req", {63'h0, dl_ready}, 64'h0);
         if (ack_en && wcnt >= ack_delay) begin
            ram_ack = 1'b1;
            ack_cnt++;
            in_req = 1'b0;
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_write: actual=%0h:%0h expected=none", ram_addr, ram_data);
            end else begin
               e = exp_q.pop_front();
               check("wr_addr", {48'h0, ram_addr}, {48'h0, e.a});
               check("wr_data", {56'h0, ram_data}, {56'h0, e.d});
            end
         end else begin
            wcnt++;
         end
      end else begin
         in_req = 1'b0;
         wcnt   = 0;
      end
      if (reset_n) begin
         if (done)  done_cnt++;
         if (error) err_cnt++;
      end
   end

   // Asynchronous reset injector: fires during an armed write, holds until disarmed.
   always @(negedge clk_sys) begin
      if (inject_at >= 0 && inject_cnt == inj_seen && ram_req && (ack_cnt - ack_base) == inject_at) begin
         #2 rst_inj_n = 1'b0;
         #1 check("rst_outputs_zero",
                  {18'h0, ram_req, busy, done, error, overflow, dl_ready, end_addr, ram_addr, ram_data},
                  64'h0);
         inject_cnt++;
      end else if (inject_at < 0) begin
         rst_inj_n = 1'b1;
      end
   end

   // Session-level reference: expected writes, end address and overflow.
   task automatic model_session(input logic [15:0] base, input byte_q_t pl,
                                output logic [15:0] e_end, output logic e_ovf, output int n_wr);
      int  a;
      wr_t w;
      n_wr = 0;
      for (int i = 0; i < pl.size(); i++) begin
         a = int'(base) + i;
         if (a <= 'hFFFF) begin
            w.a = a[15:0];
            w.d = pl[i];
            exp_q.push_back(w);
            n_wr++;
         end
      end
      e_ovf = (int'(base) + pl.size()) > 'hFFFF;
      e_end = e_ovf ? 16'h0000 : 16'(int'(base) + pl.size());
`ifdef PRG_PTR_PATCH_EN
      for (int i = 0; i < 8; i++) begin
         w.a = {8'h00, c_ptrs[63-8*i -: 8]};
         w.d = (i % 2 == 1) ? e_end[15:8] : e_end[7:0];
         exp_q.push_back(w);
         n_wr++;
      end
`endif
   endtask

   task automatic send_byte(input logic [7:0] b, output bit ok);
      int t;
      t  = 0;
      ok = 1'b0;
      dl_valid = 1'b1;
      dl_data  = b;
      while (t < 300 && inject_cnt == inj_seen) begin
         @(negedge clk_sys);
         if (dl_ready) begin
            @(posedge clk_sys);
            #1;
            ok = 1'b1;
            break;
         end
         t++;
      end
      dl_valid = 1'b0;
      if (!ok && inject_cnt == inj_seen) begin
         n_cmp++;
         n_bad++;
         $display("FAIL byte_accept_timeout: actual=not_ready expected=accepted byte=%0h", b);
      end
   endtask

   task automatic send_stream(input logic [15:0] base, input byte_q_t pl);
      bit ok;
      int g;
      dl_active = 1'b1;
      send_byte(base[7:0], ok);
      send_byte(base[15:8], ok);
      foreach (pl[i]) begin
         g = $urandom_range(0, 2);
         if (g > 0) begin
            repeat (g) @(posedge clk_sys);
            #1;
         end
         send_byte(pl[i], ok);
      end
      dl_active = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int t;
      t = 0;
      while (busy && t < 3000) begin
         @(negedge clk_sys);
         t++;
      end
      if (busy) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s_idle_timeout: actual=busy expected=idle", tag);
      end
      repeat (3) @(negedge clk_sys);
   endtask

   task automatic end_check(input string tag, input int d0, input int e0, input int exp_done,
                            input int exp_err, input logic [15:0] e_end, input logic e_ovf);
      wait_idle(tag);
      check({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'(exp_done));
      check({tag, "_error_pulses"}, 64'(err_cnt - e0), 64'(exp_err));
      check({tag, "_writes_pending"}, 64'(exp_q.size()), 64'h0);
      check({tag, "_overflow"}, {63'h0, overflow}, {63'h0, e_ovf});
      if (exp_done > 0)
         check({tag, "_end_addr"}, {48'h0, end_addr}, {48'h0, e_end});
   endtask

   task automatic run_session(input string tag, input logic [15:0] base, input byte_q_t pl,
                              input int delay, input bit chk_req);
      logic [15:0] e_end;
      logic        e_ovf;
      int          n_wr, d0, e0, r0;
      model_session(base, pl, e_end, e_ovf, n_wr);
      ack_delay = delay;
      ack_en    = 1'b1;
      d0 = done_cnt;
      e0 = err_cnt;
      r0 = req_cycles;
      send_stream(base, pl);
      end_check(tag, d0, e0, 1, 0, e_end, e_ovf);
      if (chk_req)
         check({tag, "_req_cycles"}, 64'(req_cycles - r0), 64'(n_wr * (delay + 1)));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: actual=running expected=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      byte_q_t     pl;
      logic [15:0] base, e_end;
      logic        e_ovf;
      int          n_wr, d0, e0, r0, t;
      bit          ok;

      repeat (3) @(posedge clk_sys);
      #1;
      check("reset_state",
            {18'h0, ram_req, busy, done, error, overflow, dl_ready, end_addr, ram_addr, ram_data}, 64'h0);
      rst_main_n = 1'b1;
      repeat (2) @(negedge clk_sys);

      pl = '{8'hAA, 8'hBB, 8'hCC};
      run_session("basic_ack0", 16'h1001, pl, 0, 1'b1);
      run_session("basic_ack5", 16'h1001, pl, 5, 1'b1);

      pl = '{8'h11, 8'h22, 8'h33, 8'h44};
      run_session("wrap", 16'hFFFE, pl, 1, 1'b1);

      // Session ends after only the low header byte.
      d0 = done_cnt; e0 = err_cnt; r0 = req_cycles;
      dl_active = 1'b1;
      send_byte(8'h01, ok);
      dl_active = 1'b0;
      end_check("short_hdr", d0, e0, 0, 1, 16'h0, 1'b0);
      check("short_hdr_req_cycles", 64'(req_cycles - r0), 64'h0);

      // Arbiter never acknowledges.
      ack_en = 1'b0;
      d0 = done_cnt; e0 = err_cnt; r0 = req_cycles;
      pl = '{8'h55};
      send_stream(16'h3000, pl);
      end_check("ack_timeout", d0, e0, 0, 1, 16'h0, 1'b0);
      check("ack_timeout_req_cycles", 64'(req_cycles - r0), 64'd8);
      ack_en = 1'b1;

      // Asynchronous reset during the third patch write (third payload write without patch).
      pl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      model_session(16'h2000, pl, e_end, e_ovf, n_wr);
      ack_delay = 3;
      ack_base  = ack_cnt;
      inj_seen  = inject_cnt;
`ifdef PRG_PTR_PATCH_EN
      inject_at = 7;
`else
      inject_at = 2;
`endif
      send_stream(16'h2000, pl);
      t = 0;
      while (inject_cnt == inj_seen && t < 500) begin
         @(negedge clk_sys);
         t++;
      end
      check("rst_inject_fired", 64'(inject_cnt - inj_seen), 64'd1);
      dl_valid  = 1'b0;
      dl_active = 1'b0;
      exp_q.delete();
      repeat (2) @(negedge clk_sys);
      inject_at = -1;
      repeat (2) @(negedge clk_sys);
      inj_seen = inject_cnt;
      check("rst_release_idle", {63'h0, busy}, 64'h0);
      pl = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      run_session("after_reset", 16'h0801, pl, 0, 1'b1);

      for (int s = 0; s < 8; s++) begin
         pl.delete();
         for (int i = 0; i < $urandom_range(0, 10); i++)
            pl.push_back(8'($urandom));
         if ($urandom_range(0, 3) == 0)
            base = 16'hFFF0 + 16'($urandom_range(0, 15));
         else
            base = 16'($urandom);
         run_session($sformatf("rand%0d", s), base, pl, $urandom_range(0, 6), 1'b1);
      end

      $display("test done: total=%0d bad=%0d", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
